// File: rtl/de_write_combiner.sv
// rtl/de_write_combiner.sv - write combiner merging partial word writes ahead of the frame store
module de_write_combiner #(
    parameter int HOLD_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        de_req,
    output logic        de_ack,
    input  logic [17:0] de_addr,
    input  logic [3:0]  de_nbyte,
    input  logic        de_rnw,
    input  logic [31:0] de_w_data,
    output logic [31:0] de_r_data,
    output logic        mem_req,
    output logic [17:0] mem_addr,
    output logic [3:0]  mem_nbyte,
    output logic        mem_rnw,
    output logic [31:0] mem_w_data,
    input  logic        mem_ack,
    input  logic [31:0] mem_r_data,
    input  logic        flush,
    output logic        busy,
    output logic [15:0] merge_cnt
);

    typedef enum logic [2:0] {
        ST_EMPTY,
        ST_HOLD,
        ST_DRAIN,
        ST_READ,
        ST_RDONE
    } state_t;

    state_t      state;
    logic [17:0] held_addr;
    logic [3:0]  held_nbyte;
    logic [31:0] held_data;
    logic [2:0]  idle_cnt;
    logic        wr_hit;
    logic [31:0] merged_data;

    // Upstream acknowledge: writes into an empty or matching buffer, and read completion
    always_comb begin
        wr_hit = de_req && !de_rnw && (de_addr == held_addr);
        de_ack = 1'b0;
        case (state)
            ST_EMPTY: de_ack = de_req && !de_rnw;
            ST_HOLD:  de_ack = wr_hit;
            ST_RDONE: de_ack = 1'b1;
            default:  de_ack = 1'b0;
        endcase
    end

    // Overlay the enabled byte lanes of the incoming write onto the held word
    always_comb begin
        merged_data = held_data;
        for (int n = 0; n < 4; n++) begin
            if (!de_nbyte[n]) begin
                merged_data[8*n +: 8] = de_w_data[8*n +: 8];
            end
        end
    end

    assign busy = (state != ST_EMPTY);

    // Combiner state machine with registered frame-store request fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            held_addr  <= '0;
            held_nbyte <= '0;
            held_data  <= '0;
            idle_cnt   <= '0;
            merge_cnt  <= '0;
            mem_req    <= 1'b0;
            mem_rnw    <= 1'b0;
            mem_addr   <= '0;
            mem_nbyte  <= '0;
            mem_w_data <= '0;
            de_r_data  <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (de_req && !de_rnw) begin
                        held_addr  <= de_addr;
                        held_nbyte <= de_nbyte;
                        held_data  <= de_w_data;
                        idle_cnt   <= '0;
                        state      <= ST_HOLD;
                    end else if (de_req && de_rnw) begin
                        mem_req   <= 1'b1;
                        mem_rnw   <= 1'b1;
                        mem_addr  <= de_addr;
                        mem_nbyte <= de_nbyte;
                        state     <= ST_READ;
                    end
                end
                ST_HOLD: begin
                    // An accepted write always merges; drain is reconsidered next cycle
                    if (wr_hit) begin
                        held_data  <= merged_data;
                        held_nbyte <= held_nbyte & de_nbyte;
                        idle_cnt   <= '0;
                        if (merge_cnt != 16'hFFFF) begin
                            merge_cnt <= merge_cnt + 16'd1;
                        end
                    end else if ((held_nbyte == 4'b0000) || de_req || flush ||
                                 (idle_cnt == 3'(HOLD_TIMEOUT))) begin
                        mem_req    <= 1'b1;
                        mem_rnw    <= 1'b0;
                        mem_addr   <= held_addr;
                        mem_nbyte  <= held_nbyte;
                        mem_w_data <= held_data;
                        state      <= ST_DRAIN;
                    end else begin
                        idle_cnt <= idle_cnt + 3'd1;
                    end
                end
                ST_DRAIN: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= ST_EMPTY;
                    end
                end
                ST_READ: begin
                    if (mem_ack) begin
                        de_r_data <= mem_r_data;
                        mem_req   <= 1'b0;
                        state     <= ST_RDONE;
                    end
                end
                ST_RDONE: begin
                    state <= ST_EMPTY;
                end
                default: begin
                    state <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_de_write_combiner.sv
// tb/tb_de_write_combiner.sv - randomized self-checking bench for de_write_combiner
module tb_de_write_combiner;

    localparam int TO = 4;
    localparam int M_EMPTY = 0, M_HOLD = 1, M_DRAIN = 2, M_READ = 3, M_RDONE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        de_req, de_rnw, flush, mem_ack;
    logic [17:0] de_addr;
    logic [3:0]  de_nbyte;
    logic [31:0] de_w_data, mem_r_data;
    logic        de_ack, mem_req, mem_rnw, busy;
    logic [31:0] de_r_data, mem_w_data;
    logic [17:0] mem_addr;
    logic [3:0]  mem_nbyte;
    logic [15:0] merge_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: one buffered word as bytes plus a pending-lane mask
    int          m_mode;
    logic [17:0] m_addr;
    logic [3:0]  m_mask;
    logic [7:0]  m_bytes [4];
    int          m_idle, m_cnt;
    logic        m_mreq, m_mrnw;
    logic [17:0] m_maddr;
    logic [3:0]  m_mnb;
    logic [31:0] m_mwd, m_rdata;
    logic        done;

    de_write_combiner #(.HOLD_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .de_req(de_req), .de_ack(de_ack),
        .de_addr(de_addr), .de_nbyte(de_nbyte), .de_rnw(de_rnw),
        .de_w_data(de_w_data), .de_r_data(de_r_data), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_nbyte(mem_nbyte), .mem_rnw(mem_rnw),
        .mem_w_data(mem_w_data), .mem_ack(mem_ack), .mem_r_data(mem_r_data),
        .flush(flush), .busy(busy), .merge_cnt(merge_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_EMPTY; m_addr = '0; m_mask = '0; m_idle = 0; m_cnt = 0;
        for (int i = 0; i < 4; i++) m_bytes[i] = 8'h00;
        m_mreq = 0; m_mrnw = 0; m_maddr = '0; m_mnb = '0; m_mwd = '0; m_rdata = '0;
    endtask

    // Compare at the falling edge, then advance the model to its post-edge state
    task automatic tick();
        logic exp_ack;
        @(negedge clk);
        exp_ack = (m_mode == M_EMPTY && de_req && !de_rnw) ||
                  (m_mode == M_HOLD && de_req && !de_rnw && de_addr == m_addr) ||
                  (m_mode == M_RDONE);
        chk("de_ack", 32'(de_ack), 32'(exp_ack));
        chk("busy", 32'(busy), 32'(m_mode != M_EMPTY));
        chk("mem_req", 32'(mem_req), 32'(m_mreq));
        chk("mem_rnw", 32'(mem_rnw), 32'(m_mrnw));
        chk("mem_addr", 32'(mem_addr), 32'(m_maddr));
        chk("mem_nbyte", 32'(mem_nbyte), 32'(m_mnb));
        chk("mem_w_data", mem_w_data, m_mwd);
        chk("de_r_data", de_r_data, m_rdata);
        chk("merge_cnt", 32'(merge_cnt), 32'(m_cnt));
        done = exp_ack && de_req;
        if (!rst_n) begin
            model_reset();
        end else begin
            case (m_mode)
                M_EMPTY:
                    if (de_req && !de_rnw) begin
                        m_addr = de_addr; m_mask = de_nbyte; m_idle = 0; m_mode = M_HOLD;
                        for (int i = 0; i < 4; i++) m_bytes[i] = de_w_data[8*i +: 8];
                    end else if (de_req) begin
                        m_mode = M_READ; m_mreq = 1; m_mrnw = 1; m_maddr = de_addr; m_mnb = de_nbyte;
                    end
                M_HOLD:
                    if (exp_ack) begin
                        for (int i = 0; i < 4; i++)
                            if (!de_nbyte[i]) m_bytes[i] = de_w_data[8*i +: 8];
                        m_mask = m_mask & de_nbyte;
                        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                        m_idle = 0;
                    end else if (m_mask == 4'b0000 || de_req || flush || m_idle == TO) begin
                        m_mode = M_DRAIN; m_mreq = 1; m_mrnw = 0; m_maddr = m_addr; m_mnb = m_mask;
                        m_mwd = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                    end else begin
                        m_idle++;
                    end
                M_DRAIN:
                    if (mem_ack) begin m_mreq = 0; m_mode = M_EMPTY; end
                M_READ:
                    if (mem_ack) begin m_rdata = mem_r_data; m_mreq = 0; m_mode = M_RDONE; end
                default:
                    m_mode = M_EMPTY;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic rnw, input logic [17:0] a, input logic [3:0] nb, input logic [31:0] d);
        de_req = 1; de_rnw = rnw; de_addr = a; de_nbyte = nb; de_w_data = d;
    endtask

    // Ticks until mem_req rises, bounded; returns 99 if it never does
    task automatic wait_req(output int k);
        k = 99;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (mem_req) begin k = i; break; end
        end
    endtask

    initial begin
        int k;
        rst_n = 0; de_req = 0; de_rnw = 0; de_addr = '0; de_nbyte = 4'hF; de_w_data = '0;
        flush = 0; mem_ack = 0; mem_r_data = '0; done = 0;
        model_reset();
        @(posedge clk); #1;
        tick(); tick();
        rst_n = 1;
        tick();
        chk("no_req_after_reset", 32'(mem_req), 32'd0);

        // Four byte-lane writes to one address merge into a single full write
        put(0, 18'h10, 4'b1110, 32'h000000AA); tick();
        put(0, 18'h10, 4'b1101, 32'h0000BB00); tick();
        put(0, 18'h10, 4'b1011, 32'h00CC0000); tick();
        put(0, 18'h10, 4'b0111, 32'hDD000000); tick();
        de_req = 0; tick();
        chk("merge4_req", 32'(mem_req), 32'd1);
        chk("merge4_addr", 32'(mem_addr), 32'h10);
        chk("merge4_nbyte", 32'(mem_nbyte), 32'h0);
        chk("merge4_data", mem_w_data, 32'hDDCCBBAA);
        chk("merge4_cnt", 32'(merge_cnt), 32'd3);
        mem_ack = 1; tick(); mem_ack = 0;

        // Full-word write drains one cycle after acceptance
        put(0, 18'h30, 4'b0000, 32'h01020304); tick();
        de_req = 0; wait_req(k);
        chk("full_latency", 32'(k), 32'd1);
        mem_ack = 1; tick(); mem_ack = 0;

        // Address change forces the first word out before the second is taken
        put(0, 18'h4, 4'b1110, 32'h11); tick();
        put(0, 18'h5, 4'b1101, 32'h2200); tick();
        chk("miss_nbyte", 32'(mem_nbyte), 32'hE);
        chk("miss_addr", 32'(mem_addr), 32'h4);
        mem_ack = 1; tick(); mem_ack = 0;
        tick();
        de_req = 0; wait_req(k);
        chk("timeout_latency", 32'(k), 32'd5);
        chk("second_addr", 32'(mem_addr), 32'h5);
        chk("second_nbyte", 32'(mem_nbyte), 32'hD);
        mem_ack = 1; tick(); mem_ack = 0;

        // Read behind a held write: write drains first, then the read returns data
        put(0, 18'h20, 4'b1100, 32'h0000BEEF); tick();
        put(1, 18'h20, 4'b0000, 32'h0); tick();
        chk("rd_drain_rnw", 32'(mem_rnw), 32'd0);
        chk("rd_drain_data", mem_w_data, 32'h0000BEEF);
        mem_ack = 1; tick(); mem_ack = 0;
        tick();
        chk("rd_issue", 32'({mem_req, mem_rnw}), 32'd3);
        mem_r_data = 32'h12345678; mem_ack = 1; tick(); mem_ack = 0;
        chk("rd_data", de_r_data, 32'h12345678);
        chk("rd_ack_rdone", 32'(de_ack), 32'd1);
        tick(); de_req = 0;

        // Flush right after a partial write drains it unchanged; flush alone does nothing
        put(0, 18'h40, 4'b1010, 32'h00550055); tick();
        de_req = 0; flush = 1; tick();
        chk("flush_req", 32'(mem_req), 32'd1);
        chk("flush_nbyte", 32'(mem_nbyte), 32'hA);
        mem_ack = 1; tick(); mem_ack = 0;
        tick(); tick(); tick();
        chk("flush_idle", 32'({mem_req, busy}), 32'd0);
        flush = 0;

        // Asynchronous reset in the middle of a drain
        put(0, 18'h50, 4'b0000, 32'hCAFEF00D); tick();
        de_req = 0; tick();
        chk("pre_reset_req", 32'(mem_req), 32'd1);
        #1 rst_n = 0;
        #1;
        chk("async_req", 32'(mem_req), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_cnt", 32'(merge_cnt), 32'd0);
        model_reset();
        @(posedge clk); #1;
        tick();
        rst_n = 1;
        put(0, 18'h60, 4'b0000, 32'h0BADCAFE); tick();
        de_req = 0; tick();
        chk("post_reset_data", mem_w_data, 32'h0BADCAFE);
        mem_ack = 1; tick(); mem_ack = 0;

        // Randomized traffic against the model
        done = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!de_req || done) begin
                if ($urandom_range(0, 9) < 6) begin
                    de_req = 1;
                    case ($urandom_range(0, 2))
                        0: de_addr = 18'h10;
                        1: de_addr = 18'h11;
                        default: de_addr = 18'h3FFFF;
                    endcase
                    de_nbyte = 4'($urandom_range(0, 15));
                    de_rnw = ($urandom_range(0, 3) == 0);
                    de_w_data = $urandom;
                end else begin
                    de_req = 0;
                end
            end
            flush = ($urandom_range(0, 7) == 0);
            mem_ack = m_mreq && ($urandom_range(0, 2) == 0);
            mem_r_data = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
